// File: rtl/cpu_run_ctrl.sv
// Run-state controller: global stall, staged pipeline reset, single-step/breakpoint halt
// and an advancing-cycle counter for the RV32I core.
module cpu_run_ctrl #(
  parameter int unsigned N_STALL    = 2,
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned CYC_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_STALL-1:0]    i_stall_req,
  input  logic                  i_cpu_start,
  input  logic                  i_quit_cmd,
  input  logic                  i_step_cmd,
  input  logic [STEP_W-1:0]     i_step_num,
  input  logic                  i_bp_hit,
  output logic                  o_stall,
  output logic                  o_stall_dly,
  output logic                  o_stall_1shot,
  output logic                  o_rst_pipe,
  output logic [PIPE_DEPTH-1:0] o_rst_pipe_stg,
  output logic [1:0]            o_run_state,
  output logic [CYC_W-1:0]      o_cyc_cnt
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStep = 2'd2,
    StHalt = 2'd3
  } state_e;

  state_e                r_state;
  logic                  r_stall_dly;
  logic                  r_rst_pipe;
  logic [PIPE_DEPTH-1:0] r_pipe_stg;
  logic [STEP_W-1:0]     r_step_cnt;
  logic [CYC_W-1:0]      r_cyc_cnt;

  logic w_stall;
  logic w_adv;
  logic w_step_ok;
  logic w_start_rst;
  logic w_end_rst;

  always_comb begin
    w_stall     = (r_state == StIdle) | (r_state == StHalt) | (|i_stall_req);
    w_adv       = ~w_stall;
    w_step_ok   = i_step_cmd & (i_step_num != '0);
    // Only a launch from IDLE resets the pipe; resuming from HALT keeps pipeline contents.
    w_start_rst = (r_state == StIdle) & ~i_quit_cmd & (i_cpu_start | w_step_ok);
    w_end_rst   = i_quit_cmd & (r_state != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_stall_dly <= 1'b1;
      r_rst_pipe  <= 1'b0;
      r_pipe_stg  <= '0;
      r_step_cnt  <= '0;
      r_cyc_cnt   <= '0;
    end else begin
      r_stall_dly   <= w_stall;
      r_rst_pipe    <= w_start_rst | w_end_rst;
      r_pipe_stg[0] <= r_rst_pipe;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_pipe_stg[i] <= r_pipe_stg[i-1];
      end

      if (w_start_rst) begin
        r_cyc_cnt <= '0;
      end else if (w_adv && !(&r_cyc_cnt)) begin
        r_cyc_cnt <= r_cyc_cnt + CYC_W'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (i_quit_cmd) begin
            r_state <= StIdle;
          end else if (i_cpu_start) begin
            r_state <= StRun;
          end else if (w_step_ok) begin
            r_state    <= StStep;
            r_step_cnt <= i_step_num;
          end
        end
        StRun: begin
          if (i_quit_cmd) begin
            r_state <= StIdle;
          end else if (i_bp_hit) begin
            r_state <= StHalt;
          end
        end
        StStep: begin
          if (i_quit_cmd) begin
            r_state <= StIdle;
          end else if (i_bp_hit) begin
            r_state <= StHalt;
          end else if (w_adv) begin
            // Stalled cycles do not consume step budget.
            r_step_cnt <= r_step_cnt - STEP_W'(1);
            if (r_step_cnt == STEP_W'(1)) begin
              r_state <= StHalt;
            end
          end
        end
        StHalt: begin
          if (i_quit_cmd) begin
            r_state <= StIdle;
          end else if (i_cpu_start) begin
            r_state <= StRun;
          end else if (w_step_ok) begin
            r_state    <= StStep;
            r_step_cnt <= i_step_num;
          end
        end
      endcase
    end
  end

  assign o_stall        = w_stall;
  assign o_stall_dly    = r_stall_dly;
  assign o_stall_1shot  = w_stall & ~r_stall_dly;
  assign o_rst_pipe     = r_rst_pipe;
  assign o_rst_pipe_stg = r_pipe_stg;
  assign o_run_state    = r_state;
  assign o_cyc_cnt      = r_cyc_cnt;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: expected values queued at stimulus time, popped at check time.
module tb_cpu_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] i_stall_req;
  logic       i_cpu_start;
  logic       i_quit_cmd;
  logic       i_step_cmd;
  logic [7:0] i_step_num;
  logic       i_bp_hit;

  logic        o_stall, o_stall_dly, o_stall_1shot, o_rst_pipe;
  logic [3:0]  o_rst_pipe_stg;
  logic [1:0]  o_run_state;
  logic [31:0] o_cyc_cnt;

  logic        n_stall, n_stall_dly, n_stall_1shot, n_rst_pipe;
  logic [3:0]  n_rst_pipe_stg;
  logic [1:0]  n_run_state;
  logic [3:0]  n_cyc_cnt;

  cpu_run_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_stall_req    (i_stall_req),
    .i_cpu_start    (i_cpu_start),
    .i_quit_cmd     (i_quit_cmd),
    .i_step_cmd     (i_step_cmd),
    .i_step_num     (i_step_num),
    .i_bp_hit       (i_bp_hit),
    .o_stall        (o_stall),
    .o_stall_dly    (o_stall_dly),
    .o_stall_1shot  (o_stall_1shot),
    .o_rst_pipe     (o_rst_pipe),
    .o_rst_pipe_stg (o_rst_pipe_stg),
    .o_run_state    (o_run_state),
    .o_cyc_cnt      (o_cyc_cnt)
  );

  // Narrow counter instance to exercise saturation.
  cpu_run_ctrl #(.CYC_W(4)) u_dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_stall_req    (i_stall_req),
    .i_cpu_start    (i_cpu_start),
    .i_quit_cmd     (i_quit_cmd),
    .i_step_cmd     (i_step_cmd),
    .i_step_num     (i_step_num),
    .i_bp_hit       (i_bp_hit),
    .o_stall        (n_stall),
    .o_stall_dly    (n_stall_dly),
    .o_stall_1shot  (n_stall_1shot),
    .o_rst_pipe     (n_rst_pipe),
    .o_rst_pipe_stg (n_rst_pipe_stg),
    .o_run_state    (n_run_state),
    .o_cyc_cnt      (n_cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulse_cnt = 0;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (o_rst_pipe) pulse_cnt++;
  endtask

  initial begin
    rst_n       = 1'b0;
    i_stall_req = '0;
    i_cpu_start = 1'b0;
    i_quit_cmd  = 1'b0;
    i_step_cmd  = 1'b0;
    i_step_num  = '0;
    i_bp_hit    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_state", 0); push("rst_stall", 1); push("rst_stall_dly", 1);
    push("rst_1shot", 0); push("rst_rst_pipe", 0); push("rst_stg", 0); push("rst_cyc", 0);
    chk(32'(o_run_state)); chk(32'(o_stall)); chk(32'(o_stall_dly));
    chk(32'(o_stall_1shot)); chk(32'(o_rst_pipe)); chk(32'(o_rst_pipe_stg)); chk(o_cyc_cnt);
    rst_n = 1'b1;

    // Start from IDLE
    push("t1_state", 1); push("t1_stall", 0); push("t1_rst_pipe", 1); push("t1_cyc", 0);
    i_cpu_start = 1'b1;
    tick();
    i_cpu_start = 1'b0;
    chk(32'(o_run_state)); chk(32'(o_stall)); chk(32'(o_rst_pipe)); chk(o_cyc_cnt);
    push("t1_rst_pipe_clr", 0);
    tick();
    chk(32'(o_rst_pipe));
    tick(); tick(); tick();
    push("t1_stg3", 4'b1000); push("t1_cyc4", 4);
    chk(32'(o_rst_pipe_stg)); chk(o_cyc_cnt);

    // Stall request held three cycles in RUN
    i_stall_req = 2'b10;
    #1;
    push("t2_stall_a", 1); push("t2_1shot_a", 1);
    chk(32'(o_stall)); chk(32'(o_stall_1shot));
    for (int k = 0; k < 2; k++) begin
      tick();
      push("t2_stall_b", 1); push("t2_1shot_b", 0); push("t2_cyc_frozen", 4);
      chk(32'(o_stall)); chk(32'(o_stall_1shot)); chk(o_cyc_cnt);
    end
    tick();
    i_stall_req = 2'b00;
    #1;
    push("t2_stall_off", 0); push("t2_cyc_after", 4);
    chk(32'(o_stall)); chk(o_cyc_cnt);
    tick();
    push("t2_cyc_resume", 5);
    chk(o_cyc_cnt);

    // Breakpoint halt and resume
    i_bp_hit = 1'b1;
    tick();
    i_bp_hit = 1'b0;
    push("t4_state_halt", 3); push("t4_stall", 1); push("t4_1shot", 1);
    push("t4_rst_pipe", 0); push("t4_cyc", 6);
    chk(32'(o_run_state)); chk(32'(o_stall)); chk(32'(o_stall_1shot));
    chk(32'(o_rst_pipe)); chk(o_cyc_cnt);
    tick();
    push("t4_1shot_clr", 0); push("t4_cyc_hold", 6);
    chk(32'(o_stall_1shot)); chk(o_cyc_cnt);
    pulse_cnt   = 0;
    i_cpu_start = 1'b1;
    tick();
    i_cpu_start = 1'b0;
    push("t4_state_run", 1); push("t4_resume_rst", 0); push("t4_resume_cyc", 6);
    chk(32'(o_run_state)); chk(32'(o_rst_pipe)); chk(o_cyc_cnt);
    tick();
    push("t4_pulses", 0); push("t4_cyc_adv", 7);
    chk(32'(pulse_cnt)); chk(o_cyc_cnt);

    // Simultaneous commands: quit wins
    pulse_cnt   = 0;
    i_quit_cmd  = 1'b1;
    i_bp_hit    = 1'b1;
    i_cpu_start = 1'b1;
    tick();
    i_quit_cmd  = 1'b0;
    i_bp_hit    = 1'b0;
    i_cpu_start = 1'b0;
    push("t5_state", 0); push("t5_rst_pipe", 1); push("t5_cyc", 8);
    chk(32'(o_run_state)); chk(32'(o_rst_pipe)); chk(o_cyc_cnt);
    tick();
    i_quit_cmd = 1'b1;
    tick();
    i_quit_cmd = 1'b0;
    tick();
    push("t5_pulses", 1); push("t5_state_idle", 0); push("t5_cyc_held", 8);
    chk(32'(pulse_cnt)); chk(32'(o_run_state)); chk(o_cyc_cnt);

    // Zero-length step is ignored
    i_step_cmd = 1'b1;
    i_step_num = 8'd0;
    tick();
    i_step_cmd = 1'b0;
    push("t6_step0_state", 0); push("t6_step0_rst", 0);
    chk(32'(o_run_state)); chk(32'(o_rst_pipe));

    // Step 3 with a 2-cycle stall mid-way
    pulse_cnt  = 0;
    i_step_cmd = 1'b1;
    i_step_num = 8'd3;
    tick();
    i_step_cmd = 1'b0;
    push("t3_state", 2); push("t3_cyc0", 0); push("t3_rst_pipe", 1);
    chk(32'(o_run_state)); chk(o_cyc_cnt); chk(32'(o_rst_pipe));
    tick();
    push("t3_s1_state", 2); push("t3_s1_cyc", 1);
    chk(32'(o_run_state)); chk(o_cyc_cnt);
    i_stall_req = 2'b01;
    tick(); tick();
    i_stall_req = 2'b00;
    push("t3_stall_state", 2); push("t3_stall_cyc", 1);
    chk(32'(o_run_state)); chk(o_cyc_cnt);
    tick();
    push("t3_s2_state", 2); push("t3_s2_cyc", 2);
    chk(32'(o_run_state)); chk(o_cyc_cnt);
    tick();
    push("t3_halt_state", 3); push("t3_halt_cyc", 3);
    chk(32'(o_run_state)); chk(o_cyc_cnt);
    tick();
    push("t3_pulses", 1); push("t3_still_halt", 3);
    chk(32'(pulse_cnt)); chk(32'(o_run_state));

    // Counter saturation on the 4-bit instance
    i_quit_cmd = 1'b1;
    tick();
    i_quit_cmd  = 1'b0;
    i_cpu_start = 1'b1;
    tick();
    i_cpu_start = 1'b0;
    repeat (19) tick();
    push("t6_cyc32", 19); push("t6_cyc4_sat", 15);
    chk(o_cyc_cnt); chk(32'(n_cyc_cnt));

    // Asynchronous reset mid-run
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_state", 0); push("arst_cyc", 0); push("arst_stall_dly", 1); push("arst_rst_pipe", 0);
    chk(32'(o_run_state)); chk(o_cyc_cnt); chk(32'(o_stall_dly)); chk(32'(o_rst_pipe));
    tick();
    push("arst_hold_stg", 0);
    chk(32'(o_rst_pipe_stg));
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
